// File: rtl/seq_det_rr_arbiter.sv
// ---------------------------------------------------------------------------
// seq_det_rr_arbiter
//   One AA-BB-CC byte-sequence matcher shared among N_CH byte-stream
//   requesters. A round-robin arbiter grants one channel at a time for a
//   burst of up to BURST_LEN bytes. Each channel keeps its own 2-bit matcher
//   context, so a pattern split across bursts still matches.
//
// Ports
//   clk        in   1        clock
//   rst_n      in   1        asynchronous active-low reset
//   req        in   N_CH     req[i]=1: channel i presents a valid byte
//   data       in   N_CH*8   channel i byte on data[8*i+7:8*i]
//   gnt        out  N_CH     one-hot grant from registered state, 0 when idle
//   hit        out  1        1-cycle pulse: owner completed AA,BB,CC
//   hit_ch     out  CH_W     channel that produced hit (valid when hit=1)
//   cnt_clr    in   1        (SEQ_ARB_MATCH_CNT_EN only) clear match_cnt
//   match_cnt  out  16       (SEQ_ARB_MATCH_CNT_EN only) saturating hit count
//
// Build option
//   SEQ_ARB_MATCH_CNT_EN : adds the saturating hit counter and its ports.
// ---------------------------------------------------------------------------
module seq_det_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int BURST_LEN = 8,
    localparam int CH_W     = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     req,
    input  logic [N_CH*8-1:0]   data,
    output logic [N_CH-1:0]     gnt,
    output logic                hit,
    output logic [CH_W-1:0]     hit_ch
`ifdef SEQ_ARB_MATCH_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [15:0]         match_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;
    typedef enum logic [1:0] {C_IDLE, C_AA, C_BB} ctx_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [CH_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  count_q, count_d;
    ctx_t              ctx_q [N_CH];
    ctx_t              ctx_d [N_CH];
    logic              hit_q, hit_d;
    logic [CH_W-1:0]   hit_ch_q, hit_ch_d;

    logic              consume;
    logic              match;
    logic [7:0]        cur_byte;
    logic [CH_W-1:0]   rr_pick;
    logic              rr_found;

    // Round-robin pick: first requesting channel after last_owner, wrapping.
    always_comb begin
        rr_pick  = last_owner_q;
        rr_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!rr_found && req[(int'(last_owner_q) + i) % N_CH]) begin
                rr_pick  = CH_W'((int'(last_owner_q) + i) % N_CH);
                rr_found = 1'b1;
            end
        end
    end

    // Next-state logic: arbiter FSM, burst counter and owner's matcher context.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        ctx_d        = ctx_q;
        consume      = 1'b0;
        match        = 1'b0;
        cur_byte     = data[{owner_q, 3'b000} +: 8];

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = rr_pick;
                    state_d = S_GRANT;
                    count_d = '0;
                end
            end
            S_GRANT: begin
                if (req[owner_q]) begin
                    consume = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d      = S_IDLE;
                        last_owner_d = owner_q;
                    end
                end else begin
                    state_d      = S_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Matcher update, priority order: AA always restarts the pattern.
        if (consume) begin
            if (cur_byte == 8'hAA) begin
                ctx_d[owner_q] = C_AA;
            end else if (ctx_q[owner_q] == C_AA && cur_byte == 8'hBB) begin
                ctx_d[owner_q] = C_BB;
            end else if (ctx_q[owner_q] == C_BB && cur_byte == 8'hCC) begin
                ctx_d[owner_q] = C_IDLE;
                match          = 1'b1;
            end else begin
                ctx_d[owner_q] = C_IDLE;
            end
        end

        hit_d    = match;
        hit_ch_d = match ? owner_q : hit_ch_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= CH_W'(N_CH - 1);
            count_q      <= '0;
            hit_q        <= 1'b0;
            hit_ch_q     <= '0;
            // NOTE: the per-channel contexts are live state, not a data RAM, so they take the reset too.
            for (int i = 0; i < N_CH; i++) ctx_q[i] <= C_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
            hit_q        <= hit_d;
            hit_ch_q     <= hit_ch_d;
            ctx_q        <= ctx_d;
        end
    end

    // Output logic: grant decoded from registered state only, so it drops
    // together with the asynchronous reset.
    always_comb begin
        gnt = '0;
        if (state_q == S_GRANT) gnt[owner_q] = 1'b1;
    end

    assign hit    = hit_q;
    assign hit_ch = hit_ch_q;

`ifdef SEQ_ARB_MATCH_CNT_EN
    logic [15:0] match_cnt_q, match_cnt_d;

    // Clear wins over a coincident hit; count sticks at all-ones.
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (cnt_clr) begin
            match_cnt_d = '0;
        end else if (hit_q && match_cnt_q != 16'hFFFF) begin
            match_cnt_d = match_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_cnt_q <= '0;
        else        match_cnt_q <= match_cnt_d;
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_det_rr_arbiter
//   Directed bench for seq_det_rr_arbiter (N_CH=4, BURST_LEN=8). Stimulus
//   pushes the expected hit channel into a queue when the completing byte is
//   consumed; a monitor pops and compares whenever the DUT pulses hit.
// ---------------------------------------------------------------------------
module tb_seq_det_rr_arbiter;

    localparam int N_CH      = 4;
    localparam int BURST_LEN = 8;
    localparam int CH_W      = $clog2(N_CH);

    logic              clk;
    logic              rst_n;
    logic [N_CH-1:0]   req;
    logic [N_CH*8-1:0] data;
    logic [N_CH-1:0]   gnt;
    logic              hit;
    logic [CH_W-1:0]   hit_ch;
`ifdef SEQ_ARB_MATCH_CNT_EN
    logic              cnt_clr;
    logic [15:0]       match_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q [$];

    seq_det_rr_arbiter #(.N_CH(N_CH), .BURST_LEN(BURST_LEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .hit    (hit),
        .hit_ch (hit_ch)
`ifdef SEQ_ARB_MATCH_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every hit pulse must match the oldest expected channel.
    always @(negedge clk) begin
        if (rst_n && hit) begin
            if (exp_q.size() == 0) check("unexpected_hit", int'(hit_ch) + 1, 0);
            else                   check("hit_ch", int'(hit_ch), exp_q.pop_front());
        end
    end

    // Present one byte on channel ch and wait until it is consumed.
    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input int ch, input logic [7:0] b, input bit exp_hit);
        int waited = 0;
        req[ch]        = 1'b1;
        data[8*ch +: 8] = b;
        while (!gnt[ch] && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!gnt[ch]) begin
            check("grant_timeout", ch, ch + 100);
        end else begin
            @(posedge clk); #1;
            if (exp_hit) exp_q.push_back(ch);
        end
    endtask

    task automatic drain(input string name);
        req = '0;
        repeat (4) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
`ifdef SEQ_ARB_MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_hit_ch", int'(hit_ch), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: ch0 alone; 1-cycle arbitration latency, then AA,BB,CC hits.
        req[0]   = 1'b1;
        data[7:0] = 8'hAA;
        check("t1_gnt_same_cycle", int'(gnt), 0);
        @(posedge clk); #1;
        check("t1_gnt_latency", int'(gnt), 4'b0001);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b1);
        drain("t1_pending");

        // T2: ch1 context survives a release between BB and CC.
        send(1, 8'hAA, 1'b0);
        send(1, 8'hBB, 1'b0);
        req[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t2_gnt_released", int'(gnt), 0);
        send(1, 8'hCC, 1'b1);
        drain("t2_pending");

        // T3: ch2 sending CC in between must not borrow ch1's context.
        send(1, 8'hAA, 1'b0);
        send(1, 8'hBB, 1'b0);
        req[1] = 1'b0;
        send(2, 8'hCC, 1'b0);
        req[2] = 1'b0;
        send(1, 8'hCC, 1'b1);
        drain("t3_pending");

        // T4: all channels requesting: 0,1,2,3,0, 8 bytes each, 1 idle gap.
        do_reset();
        req  = 4'hF;
        data = '0;
        @(posedge clk); #1;
        for (int seg = 0; seg < 5; seg++) begin
            for (int k = 0; k < BURST_LEN; k++) begin
                check($sformatf("t4_burst%0d_byte%0d", seg, k), int'(gnt), 1 << (seg % N_CH));
                @(posedge clk); #1;
            end
            check($sformatf("t4_gap%0d", seg), int'(gnt), 0);
            @(posedge clk); #1;
        end
        drain("t4_pending");

        // T5: ch0 streams across burst boundaries; the 8th byte is a CC
        // completing a match (last byte of a burst still hits).
        do_reset();
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hDD, 1'b0);
        send(0, 8'hCC, 1'b0);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b1);
        check("t5_burst_end_gap", int'(gnt), 0);
        @(posedge clk); #1;
        check("t5_self_regrant", int'(gnt), 4'b0001);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b1);
        drain("t5_pending");

        // T6: reset mid-burst after AA,BB: grant drops at once, context clears.
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        check("t6_gnt_before_rst", int'(gnt), 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gnt_async_drop", int'(gnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'hCC, 1'b0);
        drain("t6_pending");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
